// File: rtl/ex_mdu.sv
// ex_mdu: iterative multiply/divide unit with architectural HI/LO registers.
// Multiply is shift-add retiring MUL_STEP multiplier bits per cycle; divide is
// restoring, one quotient bit per cycle. Signed ops work on magnitudes and
// fix up the signs in the commit cycle.
module ex_mdu #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             stallreq,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int N_MUL = WIDTH / MUL_STEP;
    localparam int CW    = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc, r_mcand;
    logic [WIDTH-1:0]   r_sh;        // multiplier (MUL) or dividend/quotient shifter (DIV)
    logic [WIDTH-1:0]   r_divisor, r_src1, r_rem, r_hi, r_lo;
    logic               r_neg_q, r_neg_r, r_dz;

    logic               w_issue, w_arith, w_signed, w_last, w_s1_neg, w_s2_neg;
    logic [WIDTH-1:0]   w_mag1, w_mag2;
    logic [2*WIDTH-1:0] w_acc_nxt, w_prod;
    logic [WIDTH:0]     w_rem_sh, w_trial;
    logic [WIDTH-1:0]   w_rem_nxt, w_quo_nxt, w_quo, w_remv;

    assign w_issue  = (r_state == S_IDLE) && start && !flush;
    assign w_arith  = w_issue && !op[2];
    assign w_signed = !op[0];
    assign w_s1_neg = w_signed && src1[WIDTH-1];
    assign w_s2_neg = w_signed && src2[WIDTH-1];
    assign w_mag1   = w_s1_neg ? -src1 : src1;
    assign w_mag2   = w_s2_neg ? -src2 : src2;
    assign w_last   = (r_cnt == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic; flush aborts iterations but never a committed DONE
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_arith) w_next = op[1] ? S_DIV : S_MUL;
            S_MUL, S_DIV: begin
                if (flush)       w_next = S_IDLE;
                else if (w_last) w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy     = (r_state == S_MUL) || (r_state == S_DIV);
        done     = (r_state == S_DONE);
        stallreq = w_arith || busy;
    end

    // One shift-add step and one restoring-division step
    always_comb begin
        w_acc_nxt = r_acc;
        for (int unsigned j = 0; j < MUL_STEP; j++) begin
            if (r_sh[j]) w_acc_nxt = w_acc_nxt + (r_mcand << j);
        end
        w_rem_sh = {r_rem, r_sh[WIDTH-1]};
        w_trial  = w_rem_sh - {1'b0, r_divisor};
        if (!w_trial[WIDTH]) begin
            w_rem_nxt = w_trial[WIDTH-1:0];
            w_quo_nxt = {r_sh[WIDTH-2:0], 1'b1};
        end else begin
            w_rem_nxt = w_rem_sh[WIDTH-1:0];
            w_quo_nxt = {r_sh[WIDTH-2:0], 1'b0};
        end
        w_prod = r_neg_q ? -w_acc_nxt : w_acc_nxt;
        w_quo  = r_neg_q ? -w_quo_nxt : w_quo_nxt;
        w_remv = r_neg_r ? -w_rem_nxt : w_rem_nxt;
    end

    // Iteration registers: load on issue, advance each MUL/DIV cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_sh      <= '0;
            r_divisor <= '0;
            r_src1    <= '0;
            r_rem     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dz      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_arith) begin
                    r_cnt     <= op[1] ? CW'(WIDTH - 1) : CW'(N_MUL - 1);
                    r_acc     <= '0;
                    r_mcand   <= {{WIDTH{1'b0}}, w_mag1};
                    r_sh      <= op[1] ? w_mag1 : w_mag2;
                    r_divisor <= w_mag2;
                    r_src1    <= src1;
                    r_rem     <= '0;
                    r_neg_q   <= w_s1_neg ^ w_s2_neg;
                    r_neg_r   <= w_s1_neg;
                    r_dz      <= (src2 == '0);
                end
                S_MUL: if (!flush) begin
                    r_acc   <= w_acc_nxt;
                    r_mcand <= r_mcand << MUL_STEP;
                    r_sh    <= r_sh >> MUL_STEP;
                    r_cnt   <= r_cnt - CW'(1);
                end
                S_DIV: if (!flush) begin
                    r_rem <= w_rem_nxt;
                    r_sh  <= w_quo_nxt;
                    r_cnt <= r_cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    // HI/LO: MTHI/MTLO in IDLE, commit on the last iteration
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_issue && op == 3'd4) begin
            r_hi <= src1;
        end else if (w_issue && op == 3'd5) begin
            r_lo <= src1;
        end else if (r_state == S_MUL && !flush && w_last) begin
            {r_hi, r_lo} <= w_prod;
        end else if (r_state == S_DIV && !flush && w_last) begin
            if (r_dz) begin
                r_hi <= r_src1;
                r_lo <= '1;
            end else begin
                r_hi <= w_remv;
                r_lo <= w_quo;
            end
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule

// File: tb/tb_ex_mdu.sv
// Scoreboard bench for ex_mdu: stimulus pushes expected HI/LO and stall length,
// per-instance monitors pop and compare on every done pulse.
module tb_ex_mdu;
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          stalls;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0, start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] src1 = '0, src2 = '0;
    logic        stallreq, busy, done;
    logic [31:0] hi, lo;

    logic        flush4 = 1'b0, start4 = 1'b0;
    logic [2:0]  op4 = 3'd0;
    logic [31:0] a4 = '0, b4 = '0;
    logic        stallreq4, busy4, done4;
    logic [31:0] hi4, lo4;

    int   n_checks = 0;
    int   n_pass = 0;
    exp_t q1[$];
    exp_t q4[$];
    int   sc1 = 0;
    int   sc4 = 0;

    always #5 clk = ~clk;

    ex_mdu #(.WIDTH(32), .MUL_STEP(1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op),
        .src1(src1), .src2(src2), .stallreq(stallreq), .busy(busy),
        .done(done), .hi(hi), .lo(lo)
    );

    ex_mdu #(.WIDTH(32), .MUL_STEP(4)) u_dut4 (
        .clk(clk), .rst(rst), .flush(flush4), .start(start4), .op(op4),
        .src1(a4), .src2(b4), .stallreq(stallreq4), .busy(busy4),
        .done(done4), .hi(hi4), .lo(lo4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s", name);
    endtask

    // Monitor for the MUL_STEP=1 instance
    always @(negedge clk) begin
        exp_t e;
        if (rst) sc1 = 0;
        else if (done) begin
            if (q1.size() == 0) fail_now("unexpected_done");
            else begin
                e = q1.pop_front();
                chk("hi", {32'd0, hi}, {32'd0, e.hi});
                chk("lo", {32'd0, lo}, {32'd0, e.lo});
                chk("stall_cycles", 64'(sc1), 64'(e.stalls));
            end
            sc1 = 0;
        end else if (stallreq) sc1++;
        else sc1 = 0;
    end

    // Monitor for the MUL_STEP=4 instance
    always @(negedge clk) begin
        exp_t e;
        if (rst) sc4 = 0;
        else if (done4) begin
            if (q4.size() == 0) fail_now("unexpected_done4");
            else begin
                e = q4.pop_front();
                chk("hi4", {32'd0, hi4}, {32'd0, e.hi});
                chk("lo4", {32'd0, lo4}, {32'd0, e.lo});
                chk("stall_cycles4", 64'(sc4), 64'(e.stalls));
            end
            sc4 = 0;
        end else if (stallreq4) sc4++;
        else sc4 = 0;
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        op = o; src1 = a; src2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input int st);
        exp_t e;
        int   t;
        e.hi = ehi; e.lo = elo; e.stalls = st;
        q1.push_back(e);
        issue(o, a, b);
        t = 0;
        while (q1.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        if (q1.size() != 0) begin
            fail_now("timeout_waiting_done");
            q1.delete();
        end
        @(posedge clk);
    endtask

    initial begin
        exp_t e4;
        int   t;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        chk("rst_flags", {61'd0, done, busy, stallreq}, 64'd0);

        // MUL_STEP=4 instance: MULT -3 * 7
        e4.hi = 32'hFFFF_FFFF; e4.lo = 32'hFFFF_FFEB; e4.stalls = 9;
        q4.push_back(e4);
        @(posedge clk); #1;
        op4 = 3'd0; a4 = 32'hFFFF_FFFD; b4 = 32'd7; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        t = 0;
        while (q4.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        if (q4.size() != 0) begin
            fail_now("timeout_waiting_done4");
            q4.delete();
        end

        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33);
        run_op(3'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 33);
        run_op(3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 33);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        run_op(3'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33);
        run_op(3'd3, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 33);
        run_op(3'd3, 32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF, 33);
        run_op(3'd2, 32'hFFFF_FFFA, 32'd0,         32'hFFFF_FFFA, 32'hFFFF_FFFF, 33);

        // MTHI / MTLO: no stall, visible the next cycle
        @(posedge clk); #1;
        op = 3'd4; src1 = 32'h1234; start = 1'b1;
        @(negedge clk);
        chk("mthi_stall", {63'd0, stallreq}, 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("mthi_hi", {32'd0, hi}, 64'h1234);
        @(posedge clk); #1;
        op = 3'd5; src1 = 32'h5678; start = 1'b1;
        @(negedge clk);
        chk("mtlo_stall", {63'd0, stallreq}, 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("mtlo_lo", {32'd0, lo}, 64'h5678);
        chk("mtlo_hi_kept", {32'd0, hi}, 64'h1234);

        // op 6 is a no-op
        issue(3'd6, 32'hDEAD_BEEF, 32'd1);
        chk("noop_idle", {62'd0, busy, stallreq}, 64'd0);
        chk("noop_hilo", {hi, lo}, 64'h0000_1234_0000_5678);

        // DIVU flushed in its 10th iteration
        issue(3'd3, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        chk("pre_flush_busy", {63'd0, busy}, 64'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_idle", {62'd0, busy, stallreq}, 64'd0);
        chk("flush_hilo", {hi, lo}, 64'h0000_1234_0000_5678);
        repeat (40) @(posedge clk);

        // Reset in the middle of a multiply
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_hilo", {hi, lo}, 64'd0);
        chk("rst_mid_flags", {61'd0, done, busy, stallreq}, 64'd0);
        rst = 1'b0;

        // flush together with start in IDLE
        @(posedge clk); #1;
        op = 3'd1; src1 = 32'd5; src2 = 32'd5; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("flush_start_stall", {63'd0, stallreq}, 64'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", {63'd0, busy}, 64'd0);
        repeat (40) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
